dm_burst_ctrl: RTL and testbench
================================

# dm_burst_ctrl

Sequencer that turns a single block memory request (start address, word count, direction) into the DMI transaction sequence the debug module needs for 32-bit abstract memory access with post-increment. It sits between a host-side requester (DTM or test harness) and the debug module's DMI slave port. Per burst, it:
- loads the address into DATA1 once;
- for each word, issues access-memory commands, polls ABSTRACTCS.busy and moves words through DATA0;
- recovers from command errors by clearing cmderr.

## Interface
Parameters:
- POLL_LIMIT, 256: ABSTRACTCS polls per word before timeout.

Ports:
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-high
- cmd_valid  in  1  burst request
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write memory, 0 = read
- cmd_addr  in  32  byte start address, word aligned
- cmd_len  in  8  word count minus 1 (1..256 words)
- wr_valid / wr_ready  in/out  1/1  write-word stream, accepted on valid && ready
- wr_data  in  32  write word
- rd_valid / rd_ready  out/in  1/1  read-word stream, transferred on valid && ready
- rd_data  out  32  read word
- done  out  1  one-cycle pulse at burst end
- err  out  2  valid with done: 0 ok, 1 cmderr, 2 poll timeout
- words_done  out  9  words completed in current or last burst
- dmi_valid  out  1  DMI request
- dmi_ready  in  1  DMI accept
- dmi_write  out  1  DMI write
- dmi_addr  out  7  DMI register address
- dmi_wdata  out  32  DMI write data
- dmi_rdata  in  32  DMI read data; valid the cycle after a read handshake

## Operation
- DMI addresses: DATA0 0x04, DATA1 0x05, ABSTRACTCS 0x16, COMMAND 0x17.
- ABSTRACTCS fields: busy = bit 12, cmderr = bits 10:8.
- COMMAND words: read 0x0228_0000, write 0x0229_0000 (cmdtype 2, aamsize 2, aampostincrement 1, write bit 16).
- Each DMI transaction has two phases:
  - ISSUE: dmi_valid high with stable write/addr/wdata until dmi_valid && dmi_ready.
  - RESP: exactly one cycle with dmi_valid low; dmi_rdata sampled here for reads.
- State sequence:
  - IDLE: latch cmd_* on cmd_valid && cmd_ready; clear words_done → SET_ADDR.
  - SET_ADDR: write DATA1 = addr → write ? WAIT_WR : CMD.
  - WAIT_WR: hold until wr_valid (wr_ready high in this state only); latch wr_data → LOAD_D0.
  - LOAD_D0: write DATA0 = latched word → CMD.
  - CMD: write COMMAND (read or write word) → POLL.
  - POLL: read ABSTRACTCS, then:
    - cmderr != 0 → CLR with err = 1;
    - else busy = 1 → POLL again, poll counter + 1;
    - else busy = 0 → write ? NEXT : GET_D0.
  - POLL timeout: counter reaching POLL_LIMIT with busy still set → CLR with err = 2.
  - GET_D0: read DATA0 → PUSH.
  - PUSH: rd_valid high with rd_data stable until rd_ready → NEXT.
  - NEXT: words_done + 1; if words_done + 1 == len + 1 → DONE, else write ? WAIT_WR : CMD. DATA1 is not rewritten; the module post-increments it.
  - CLR: write ABSTRACTCS = 0x0000_0700 → DONE.
  - DONE: done = 1 for one cycle → IDLE. err holds until the next burst is accepted.
- Poll counter clears on entry to CMD.
- No new DMI request is issued while a transaction is in ISSUE or RESP.
- Reset values: all outputs 0 except cmd_ready = 1. State = IDLE; counters cleared.
- Reset mid-burst: dmi_valid, rd_valid and wr_ready drop immediately (asynchronous). The burst is abandoned with no done pulse.
- cmd_valid while not IDLE: ignored (cmd_ready = 0).
- Errors stop the burst:
  - Remaining write words are not consumed; remaining read words are not produced.
  - words_done reports completed words only.

## Timing
- With a DMI slave that asserts ready one cycle after valid, each transaction takes 3 cycles (valid, handshake, RESP).
- Read word, busy cleared on first poll: CMD 3 + POLL 3 + GET_D0 3 + PUSH ≥ 1 + NEXT 1 = 11 cycles.
- Write word with wr_valid already high: WAIT_WR 1 + LOAD_D0 3 + CMD 3 + POLL 3 + NEXT 1 = 11 cycles.
- Burst overhead: IDLE accept 1 + SET_ADDR 3 + DONE 1.
- Each extra busy poll adds 3 cycles.
- words_done updates the cycle after NEXT.

## Test plan
- Read burst: addr 0x8000_0000, len 3, model returns 0x11, 0x22, 0x33, 0x44 → DMI writes 0x05←0x8000_0000 once, 4× 0x17←0x0228_0000. rd stream yields 0x11..0x44; done with err 0; words_done 4.
- Write burst: len 1, stream 0xDEAD_BEEF, 0x0BAD_F00D → DMI writes 0x04←0xDEAD_BEEF, 0x17←0x0229_0000, 0x04←0x0BAD_F00D, 0x17←0x0229_0000. err 0; words_done 2.
- Busy three polls: first word's ABSTRACTCS returns 0x1000 twice then 0 → word 1 latency 17 cycles. No extra COMMAND write.
- Cmderr: second word's ABSTRACTCS returns 0x0300 → 0x16←0x0000_0700 issued. done with err 1; words_done 1; no further rd_valid.
- Timeout: POLL_LIMIT 4, busy stuck → exactly 4 polls then CLR; err 2.
- Backpressure and reset: rd_ready low 5 cycles → rd_data stable, no DMI traffic. Assert reset mid-POLL → dmi_valid 0 same cycle; cmd_ready 1 after release.

Source files
------------

// File: rtl/dm_burst_ctrl.sv
// dm_burst_ctrl: turns one block memory request into the DMI sequence for 32-bit
// abstract memory access with post-increment (DATA1 once, then COMMAND/poll/DATA0 per word).
module dm_burst_ctrl #(
  parameter int POLL_LIMIT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic        done,
  output logic [1:0]  err,
  output logic [8:0]  words_done,
  output logic        dmi_valid,
  input  logic        dmi_ready,
  output logic        dmi_write,
  output logic [6:0]  dmi_addr,
  output logic [31:0] dmi_wdata,
  input  logic [31:0] dmi_rdata
);

  localparam logic [6:0]  ADDR_DATA0      = 7'h04;
  localparam logic [6:0]  ADDR_DATA1      = 7'h05;
  localparam logic [6:0]  ADDR_ABSTRACTCS = 7'h16;
  localparam logic [6:0]  ADDR_COMMAND    = 7'h17;
  localparam logic [31:0] CMD_READ_WORD   = 32'h0228_0000;
  localparam logic [31:0] CMD_WRITE_WORD  = 32'h0229_0000;
  localparam logic [31:0] CMDERR_CLEAR    = 32'h0000_0700;
  localparam int          PCW             = $clog2(POLL_LIMIT + 1);

  localparam logic [1:0]  ERR_NONE    = 2'd0;
  localparam logic [1:0]  ERR_CMDERR  = 2'd1;
  localparam logic [1:0]  ERR_TIMEOUT = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_SET_ADDR = 4'd1,
    S_WAIT_WR  = 4'd2,
    S_LOAD_D0  = 4'd3,
    S_CMD      = 4'd4,
    S_POLL     = 4'd5,
    S_GET_D0   = 4'd6,
    S_PUSH     = 4'd7,
    S_NEXT     = 4'd8,
    S_CLR      = 4'd9,
    S_DONE     = 4'd10
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             phase_r;      // 0: ISSUE, 1: RESP
  logic             phase_nxt_s;

  logic [7:0]       len_r;
  logic             write_r;
  logic [8:0]       words_done_r;
  logic [PCW-1:0]   poll_cnt_r;
  logic [1:0]       err_r;
  logic [31:0]      rd_data_r;

  logic             cmd_ready_r;
  logic             wr_ready_r;
  logic             rd_valid_r;
  logic             done_r;
  logic             dmi_valid_r;
  logic             dmi_write_r;
  logic [6:0]       dmi_addr_r;
  logic [31:0]      dmi_wdata_r;

  logic             cmd_ready_s;
  logic             wr_ready_s;
  logic             rd_valid_s;
  logic             done_s;
  logic             dmi_valid_s;
  logic             dmi_write_s;
  logic [6:0]       dmi_addr_s;
  logic [31:0]      dmi_wdata_s;

  logic             accept_s;
  logic             dmi_hs_s;
  logic             poll_resp_s;
  logic             busy_s;
  logic             cmderr_s;
  logic             poll_last_s;
  logic             last_word_s;
  logic             enter_cmd_s;

  function automatic logic is_dmi_state(input state_t s);
    case (s)
      S_SET_ADDR, S_LOAD_D0, S_CMD, S_POLL, S_GET_D0, S_CLR: is_dmi_state = 1'b1;
      default:                                               is_dmi_state = 1'b0;
    endcase
  endfunction

  assign accept_s    = (state_r == S_IDLE) && cmd_valid;
  assign dmi_hs_s    = dmi_valid_r && dmi_ready;
  assign poll_resp_s = (state_r == S_POLL) && phase_r;
  assign busy_s      = dmi_rdata[12];
  assign cmderr_s    = |dmi_rdata[10:8];
  assign poll_last_s = (poll_cnt_r == PCW'(POLL_LIMIT - 1));
  assign last_word_s = (words_done_r == {1'b0, len_r});
  assign enter_cmd_s = (state_nxt_s == S_CMD) && (state_r != S_CMD);

  // State and DMI phase registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      phase_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      phase_r <= phase_nxt_s;
    end
  end

  // Next-state logic; DMI states only advance at the end of their RESP cycle
  always_comb begin
    state_nxt_s = state_r;
    phase_nxt_s = 1'b0;
    if (is_dmi_state(state_r)) begin
      if (phase_r) begin
        phase_nxt_s = 1'b0;
      end else if (dmi_hs_s) begin
        phase_nxt_s = 1'b1;
      end else begin
        phase_nxt_s = 1'b0;
      end
    end else begin
      phase_nxt_s = 1'b0;
    end

    case (state_r)
      S_IDLE: begin
        if (cmd_valid) state_nxt_s = S_SET_ADDR;
        else           state_nxt_s = S_IDLE;
      end
      S_SET_ADDR: begin
        if (phase_r) state_nxt_s = write_r ? S_WAIT_WR : S_CMD;
        else         state_nxt_s = S_SET_ADDR;
      end
      S_WAIT_WR: begin
        if (wr_valid && wr_ready_r) state_nxt_s = S_LOAD_D0;
        else                        state_nxt_s = S_WAIT_WR;
      end
      S_LOAD_D0: begin
        if (phase_r) state_nxt_s = S_CMD;
        else         state_nxt_s = S_LOAD_D0;
      end
      S_CMD: begin
        if (phase_r) state_nxt_s = S_POLL;
        else         state_nxt_s = S_CMD;
      end
      S_POLL: begin
        if (!phase_r)          state_nxt_s = S_POLL;
        else if (cmderr_s)     state_nxt_s = S_CLR;
        else if (busy_s)       state_nxt_s = poll_last_s ? S_CLR : S_POLL;
        else                   state_nxt_s = write_r ? S_NEXT : S_GET_D0;
      end
      S_GET_D0: begin
        if (phase_r) state_nxt_s = S_PUSH;
        else         state_nxt_s = S_GET_D0;
      end
      S_PUSH: begin
        if (rd_valid_r && rd_ready) state_nxt_s = S_NEXT;
        else                        state_nxt_s = S_PUSH;
      end
      S_NEXT: begin
        if (last_word_s) state_nxt_s = S_DONE;
        else             state_nxt_s = write_r ? S_WAIT_WR : S_CMD;
      end
      S_CLR: begin
        if (phase_r) state_nxt_s = S_DONE;
        else         state_nxt_s = S_CLR;
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Output decode from the next state so every output comes straight from a flop
  always_comb begin
    cmd_ready_s = (state_nxt_s == S_IDLE);
    wr_ready_s  = (state_nxt_s == S_WAIT_WR);
    rd_valid_s  = (state_nxt_s == S_PUSH);
    done_s      = (state_nxt_s == S_DONE);
    dmi_valid_s = is_dmi_state(state_nxt_s) && !phase_nxt_s;
    dmi_write_s = 1'b0;
    dmi_addr_s  = 7'h00;
    dmi_wdata_s = 32'h0000_0000;
    case (state_nxt_s)
      S_SET_ADDR: begin
        dmi_write_s = 1'b1;
        dmi_addr_s  = ADDR_DATA1;
        if (state_r == S_IDLE) dmi_wdata_s = cmd_addr;
        else                   dmi_wdata_s = dmi_wdata_r;
      end
      S_LOAD_D0: begin
        dmi_write_s = 1'b1;
        dmi_addr_s  = ADDR_DATA0;
        if (state_r == S_WAIT_WR) dmi_wdata_s = wr_data;
        else                      dmi_wdata_s = dmi_wdata_r;
      end
      S_CMD: begin
        dmi_write_s = 1'b1;
        dmi_addr_s  = ADDR_COMMAND;
        dmi_wdata_s = write_r ? CMD_WRITE_WORD : CMD_READ_WORD;
      end
      S_POLL: begin
        dmi_write_s = 1'b0;
        dmi_addr_s  = ADDR_ABSTRACTCS;
      end
      S_GET_D0: begin
        dmi_write_s = 1'b0;
        dmi_addr_s  = ADDR_DATA0;
      end
      S_CLR: begin
        dmi_write_s = 1'b1;
        dmi_addr_s  = ADDR_ABSTRACTCS;
        dmi_wdata_s = CMDERR_CLEAR;
      end
      default: begin
        dmi_write_s = 1'b0;
        dmi_addr_s  = 7'h00;
        dmi_wdata_s = 32'h0000_0000;
      end
    endcase
  end

  // Output registers; reset drops the handshake strobes asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_ready_r <= 1'b1;
      wr_ready_r  <= 1'b0;
      rd_valid_r  <= 1'b0;
      done_r      <= 1'b0;
      dmi_valid_r <= 1'b0;
      dmi_write_r <= 1'b0;
      dmi_addr_r  <= 7'h00;
      dmi_wdata_r <= 32'h0000_0000;
    end else begin
      cmd_ready_r <= cmd_ready_s;
      wr_ready_r  <= wr_ready_s;
      rd_valid_r  <= rd_valid_s;
      done_r      <= done_s;
      dmi_valid_r <= dmi_valid_s;
      dmi_write_r <= dmi_write_s;
      dmi_addr_r  <= dmi_addr_s;
      dmi_wdata_r <= dmi_wdata_s;
    end
  end

  // Burst bookkeeping: request latch, word and poll counters, error code, read word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_r        <= 8'd0;
      write_r      <= 1'b0;
      words_done_r <= 9'd0;
      poll_cnt_r   <= '0;
      err_r        <= ERR_NONE;
      rd_data_r    <= 32'h0000_0000;
    end else begin
      if (accept_s) begin
        len_r        <= cmd_len;
        write_r      <= cmd_write;
        words_done_r <= 9'd0;
        err_r        <= ERR_NONE;
      end else if (state_r == S_NEXT) begin
        words_done_r <= words_done_r + 9'd1;
      end else if (poll_resp_s && cmderr_s) begin
        err_r <= ERR_CMDERR;
      end else if (poll_resp_s && busy_s && poll_last_s) begin
        err_r <= ERR_TIMEOUT;
      end

      // Only completed busy polls are counted, so the limit is never exceeded
      if (enter_cmd_s) begin
        poll_cnt_r <= '0;
      end else if (poll_resp_s && !cmderr_s && busy_s && !poll_last_s) begin
        poll_cnt_r <= poll_cnt_r + PCW'(1);
      end

      if ((state_r == S_GET_D0) && phase_r) begin
        rd_data_r <= dmi_rdata;
      end
    end
  end

  assign cmd_ready  = cmd_ready_r;
  assign wr_ready   = wr_ready_r;
  assign rd_valid   = rd_valid_r;
  assign rd_data    = rd_data_r;
  assign done       = done_r;
  assign err        = err_r;
  assign words_done = words_done_r;
  assign dmi_valid  = dmi_valid_r;
  assign dmi_write  = dmi_write_r;
  assign dmi_addr   = dmi_addr_r;
  assign dmi_wdata  = dmi_wdata_r;

endmodule

// File: tb/tb_dm_burst_ctrl.sv
// Bench for dm_burst_ctrl: DMI slave model with a scoreboard of expected DMI
// transactions and read words, plus a write-word feeder.
`timescale 1ns/1ps
module tb_dm_burst_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        done;
  logic [1:0]  err;
  logic [8:0]  words_done;
  logic        dmi_valid, dmi_ready, dmi_write;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata, dmi_rdata;

  dm_burst_ctrl #(.POLL_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .err(err), .words_done(words_done),
    .dmi_valid(dmi_valid), .dmi_ready(dmi_ready), .dmi_write(dmi_write),
    .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata), .dmi_rdata(dmi_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        w;
    logic [6:0]  a;
    logic [31:0] d;
  } dmi_t;

  dmi_t        exp_dmi[$];
  logic [31:0] exp_rd[$];
  logic [31:0] poll_q[$];
  logic [31:0] rdm_q[$];
  logic [31:0] wr_q[$];
  logic        stuck_busy = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push_dmi(input logic w, input logic [6:0] a, input logic [31:0] d);
    dmi_t e;
    e.w = w; e.a = a; e.d = d;
    exp_dmi.push_back(e);
  endtask

  // push the COMMAND/poll/DATA0 sequence of one read word
  task automatic push_read_word(input int n_polls);
    push_dmi(1'b1, 7'h17, 32'h0228_0000);
    for (int i = 0; i < n_polls; i++) push_dmi(1'b0, 7'h16, 32'h0);
    push_dmi(1'b0, 7'h04, 32'h0);
  endtask

  // DMI slave: ready one cycle after valid, read data driven in the RESP cycle
  initial begin
    logic        v_neg, hs, hw;
    logic [6:0]  ha;
    logic [31:0] hd, rsp;
    dmi_t        e;
    dmi_ready = 1'b0;
    dmi_rdata = 32'h0;
    forever begin
      @(negedge clk);
      v_neg = dmi_valid;
      hs    = dmi_valid && dmi_ready;
      hw = dmi_write; ha = dmi_addr; hd = dmi_wdata;
      rsp = 32'h0;
      if (hs) begin
        if (exp_dmi.size() == 0) begin
          chk_eq("dmi_extra", 32'(exp_dmi.size()), 32'd1);
        end else begin
          e = exp_dmi.pop_front();
          chk_eq("dmi_wr_addr", {24'd0, hw, ha}, {24'd0, e.w, e.a});
          if (e.w) chk_eq("dmi_wdata", hd, e.d);
        end
        if (!hw && ha == 7'h16) begin
          if (poll_q.size() != 0) rsp = poll_q.pop_front();
          else                    rsp = stuck_busy ? 32'h0000_1000 : 32'h0;
        end else if (!hw && ha == 7'h04) begin
          if (rdm_q.size() != 0) rsp = rdm_q.pop_front();
        end
      end
      @(posedge clk); #1;
      if (hs) begin
        dmi_ready = 1'b0;
        if (!hw) dmi_rdata = rsp;
      end else if (v_neg) begin
        dmi_ready = 1'b1;
      end else begin
        dmi_ready = 1'b0;
      end
    end
  end

  // write-word feeder: presents wr_q front, pops on handshake
  initial begin
    logic took;
    wr_valid = 1'b0;
    wr_data  = 32'h0;
    forever begin
      @(negedge clk);
      took = wr_valid && wr_ready;
      @(posedge clk); #1;
      if (took && wr_q.size() != 0) void'(wr_q.pop_front());
      wr_valid = (wr_q.size() != 0);
      wr_data  = (wr_q.size() != 0) ? wr_q[0] : 32'h0;
    end
  end

  // read-word monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) chk_eq("rd_extra", 32'(exp_rd.size()), 32'd1);
        else                    chk_eq("rd_data", rd_data, exp_rd.pop_front());
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_burst(input logic w, input logic [31:0] a, input logic [7:0] l,
                             output int t0);
    cmd_write = w; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    t0 = cyc;
    @(negedge clk);
    chk_eq("accept_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input int t0, output int lat,
                           output logic [1:0] e, output logic [8:0] wd);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk_eq("done_seen", {31'd0, done}, 32'd1);
    lat = cyc - t0 + 1;
    e   = err;
    wd  = words_done;
    @(posedge clk); #1;
    chk_eq("done_pulse", {31'd0, done}, 32'd0);
    chk_eq("idle_ready", {31'd0, cmd_ready}, 32'd1);
    chk_eq("err_hold", {30'd0, err}, {30'd0, e});
    chk_eq("dmi_all_seen", 32'(exp_dmi.size()), 32'd0);
    chk_eq("rd_all_seen", 32'(exp_rd.size()), 32'd0);
  endtask

  initial begin
    int          t0, lat, cnt;
    logic [1:0]  e;
    logic [8:0]  wd;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_len = 8'd0;
    rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk_eq("rst_dmi_valid", {31'd0, dmi_valid}, 32'd0);
    chk_eq("rst_outs", {20'd0, rd_valid, wr_ready, done, err, words_done}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // read burst, 4 words
    push_dmi(1'b1, 7'h05, 32'h8000_0000);
    for (int i = 0; i < 4; i++) push_read_word(1);
    rdm_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    exp_rd = '{32'h11, 32'h22, 32'h33, 32'h44};
    start_burst(1'b0, 32'h8000_0000, 8'd3, t0);
    wait_done(200, t0, lat, e, wd);
    chk_eq("rd4_err", {30'd0, e}, 32'd0);
    chk_eq("rd4_words", {23'd0, wd}, 32'd4);
    chk_eq("rd4_latency", lat, 32'd49);

    // write burst, 2 words
    wr_q = '{32'hDEAD_BEEF, 32'h0BAD_F00D};
    push_dmi(1'b1, 7'h05, 32'h1000_0000);
    push_dmi(1'b1, 7'h04, 32'hDEAD_BEEF);
    push_dmi(1'b1, 7'h17, 32'h0229_0000);
    push_dmi(1'b0, 7'h16, 32'h0);
    push_dmi(1'b1, 7'h04, 32'h0BAD_F00D);
    push_dmi(1'b1, 7'h17, 32'h0229_0000);
    push_dmi(1'b0, 7'h16, 32'h0);
    start_burst(1'b1, 32'h1000_0000, 8'd1, t0);
    wait_done(200, t0, lat, e, wd);
    chk_eq("wr2_err", {30'd0, e}, 32'd0);
    chk_eq("wr2_words", {23'd0, wd}, 32'd2);
    chk_eq("wr2_latency", lat, 32'd27);
    chk_eq("wr2_consumed", 32'(wr_q.size()), 32'd0);

    // busy on the first two polls
    poll_q = '{32'h0000_1000, 32'h0000_1000};
    rdm_q  = '{32'h77};
    exp_rd = '{32'h77};
    push_dmi(1'b1, 7'h05, 32'h4000_0010);
    push_read_word(3);
    start_burst(1'b0, 32'h4000_0010, 8'd0, t0);
    wait_done(200, t0, lat, e, wd);
    chk_eq("busy_err", {30'd0, e}, 32'd0);
    chk_eq("busy_latency", lat, 32'd22);

    // cmderr on the second word
    poll_q = '{32'h0, 32'h0000_0300};
    rdm_q  = '{32'hA1, 32'hA2};
    exp_rd = '{32'hA1};
    push_dmi(1'b1, 7'h05, 32'h4000_0100);
    push_read_word(1);
    push_dmi(1'b1, 7'h17, 32'h0228_0000);
    push_dmi(1'b0, 7'h16, 32'h0);
    push_dmi(1'b1, 7'h16, 32'h0000_0700);
    start_burst(1'b0, 32'h4000_0100, 8'd3, t0);
    wait_done(200, t0, lat, e, wd);
    chk_eq("cmderr_err", {30'd0, e}, 32'd1);
    chk_eq("cmderr_words", {23'd0, wd}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rd_valid) cnt++;
    end
    chk_eq("cmderr_no_rd", cnt, 32'd0);
    rdm_q.delete();
    @(posedge clk); #1;

    // poll timeout with busy stuck
    stuck_busy = 1'b1;
    push_dmi(1'b1, 7'h05, 32'h4000_0200);
    push_dmi(1'b1, 7'h17, 32'h0228_0000);
    for (int i = 0; i < 4; i++) push_dmi(1'b0, 7'h16, 32'h0);
    push_dmi(1'b1, 7'h16, 32'h0000_0700);
    start_burst(1'b0, 32'h4000_0200, 8'd1, t0);
    wait_done(200, t0, lat, e, wd);
    chk_eq("tmo_err", {30'd0, e}, 32'd2);
    chk_eq("tmo_words", {23'd0, wd}, 32'd0);
    chk_eq("tmo_latency", lat, 32'd23);
    stuck_busy = 1'b0;

    // read backpressure; a new request while busy is ignored
    rd_ready = 1'b0;
    rdm_q  = '{32'h5A5A_0001};
    exp_rd = '{32'h5A5A_0001};
    push_dmi(1'b1, 7'h05, 32'h4000_0300);
    push_read_word(1);
    start_burst(1'b0, 32'h4000_0300, 8'd0, t0);
    chk_eq("err_cleared", {30'd0, err}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rd_valid) break;
    end
    chk_eq("bp_rd_valid", {31'd0, rd_valid}, 32'd1);
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk_eq("bp_rd_data", rd_data, 32'h5A5A_0001);
      chk_eq("bp_dmi_idle", {31'd0, dmi_valid}, 32'd0);
      chk_eq("busy_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rd_ready  = 1'b1;
    wait_done(100, t0, lat, e, wd);
    chk_eq("bp_words", {23'd0, wd}, 32'd1);

    // reset during POLL
    push_dmi(1'b1, 7'h05, 32'h2000_0000);
    push_dmi(1'b1, 7'h17, 32'h0228_0000);
    start_burst(1'b0, 32'h2000_0000, 8'd0, t0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dmi_valid && dmi_addr == 7'h16) break;
    end
    chk_eq("rst_poll_seen", {25'd0, dmi_addr}, 32'h16);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk_eq("midrst_dmi_valid", {31'd0, dmi_valid}, 32'd0);
    chk_eq("midrst_strobes", {30'd0, rd_valid, wr_ready}, 32'd0);
    chk_eq("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_eq("midrst_dmi_q", 32'(exp_dmi.size()), 32'd0);
    exp_dmi.delete();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || dmi_valid) cnt++;
    end
    chk_eq("midrst_quiet", cnt, 32'd0);
    chk_eq("midrst_ready_after", {31'd0, cmd_ready}, 32'd1);
    chk_eq("midrst_words", {23'd0, words_done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
